// File: rtl/y86_regfile.sv
// Y86-64 register file: 15 x DATA_WID registers, two combinational read ports,
// E/M write ports with internally decoded destinations. Optional: REGFILE_WRITE_BYPASS_EN.
module y86_regfile #(
   parameter int DATA_WID = 64,
   parameter int ADDR_WID = 4
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [3:0]          icode,
   input  logic [ADDR_WID-1:0] rA,
   input  logic [ADDR_WID-1:0] rB,
   input  logic                Cnd,
   input  logic [ADDR_WID-1:0] srcA,
   input  logic [ADDR_WID-1:0] srcB,
   input  logic [DATA_WID-1:0] valE,
   input  logic [DATA_WID-1:0] valM,
   output logic [DATA_WID-1:0] valA,
   output logic [DATA_WID-1:0] valB,
   output logic [ADDR_WID-1:0] destE,
   output logic [ADDR_WID-1:0] destM
);

   localparam int NUM_REGS = 15;
   localparam logic [ADDR_WID-1:0] RNONE = '1;
   localparam logic [ADDR_WID-1:0] RRSP  = ADDR_WID'(4);

   logic [DATA_WID-1:0] regs [0:NUM_REGS-1];
   logic [DATA_WID-1:0] val_a_next;
   logic [DATA_WID-1:0] val_b_next;

   always_comb begin
      destE = RNONE;
      destM = RNONE;
      case (icode)
         4'h2:                      destE = Cnd ? rB : RNONE;
         4'h3, 4'h6:                destE = rB;
         4'h8, 4'h9, 4'hA, 4'hB:    destE = RRSP;
         default:                   destE = RNONE;
      endcase
      case (icode)
         4'h5, 4'hB: destM = rA;
         default:    destM = RNONE;
      endcase
   end

   // One flop bank per register; M is checked first so popq %rsp keeps the loaded value.
   // A destination of 0xF never matches any bank, so such writes are dropped.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         localparam logic [ADDR_WID-1:0] ID = ADDR_WID'(gi);
         logic [DATA_WID-1:0] r_reg;

         always_ff @(posedge CLK or posedge RST) begin
            if (RST)
               r_reg <= '0;
            else if (destM == ID)
               r_reg <= valM;
            else if (destE == ID)
               r_reg <= valE;
         end

         assign regs[gi] = r_reg;
      end
   endgenerate

   always_comb begin
      val_a_next = '0;
      val_b_next = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (srcA == ADDR_WID'(i)) val_a_next = regs[i];
         if (srcB == ADDR_WID'(i)) val_b_next = regs[i];
      end
   end

`ifdef REGFILE_WRITE_BYPASS_EN
   // Forward the write about to land this edge; suppressed while reset holds the file at zero.
   always_comb begin
      valA = val_a_next;
      valB = val_b_next;
      if (!RST) begin
         if (srcA != RNONE && srcA == destM)      valA = valM;
         else if (srcA != RNONE && srcA == destE) valA = valE;
         if (srcB != RNONE && srcB == destM)      valB = valM;
         else if (srcB != RNONE && srcB == destE) valB = valE;
      end
   end
`else
   assign valA = val_a_next;
   assign valB = val_b_next;
`endif

endmodule

// File: tb/tb_y86_regfile.sv
// Self-checking bench for y86_regfile: directed test-plan steps, random instructions
// compared against an architectural model, and an asynchronous reset scenario.
`timescale 1ns/1ps
module tb_y86_regfile;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  icode = 4'h1;
   logic [3:0]  rA = 4'hF, rB = 4'hF, srcA = 4'hF, srcB = 4'hF;
   logic        Cnd = 1'b0;
   logic [63:0] valE = '0, valM = '0;
   logic [63:0] valA, valB;
   logic [3:0]  destE, destM;

   int vectors = 0;
   int miscompares = 0;

   logic [63:0] model [0:15];
   logic [3:0]  cur_de = 4'hF, cur_dm = 4'hF;
   logic [63:0] cur_ve = '0, cur_vm = '0;

   y86_regfile #(.DATA_WID(64), .ADDR_WID(4)) dut (
      .CLK(CLK), .RST(RST), .icode(icode), .rA(rA), .rB(rB), .Cnd(Cnd),
      .srcA(srcA), .srcB(srcB), .valE(valE), .valM(valM),
      .valA(valA), .valB(valB), .destE(destE), .destM(destM)
   );

   always #50 CLK = ~CLK;

   function automatic logic [3:0] exp_de(input logic [3:0] ic, input logic [3:0] rb, input logic c);
      if (ic == 4'h2) return c ? rb : 4'hF;
      if (ic == 4'h3 || ic == 4'h6) return rb;
      if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] exp_dm(input logic [3:0] ic, input logic [3:0] ra);
      return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
   endfunction

   function automatic logic [63:0] exp_rd(input logic [3:0] id);
      if (RST || id == 4'hF) return 64'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (id == cur_dm) return cur_vm;
      if (id == cur_de) return cur_ve;
`endif
      return model[id];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sweep(input string tag);
      for (int id = 0; id < 16; id++) begin
         srcA = 4'(id);
         srcB = 4'(15 - id);
         #1;
         chk($sformatf("%s valA[%0d]", tag, id), valA, exp_rd(4'(id)));
         chk($sformatf("%s valB[%0d]", tag, 15 - id), valB, exp_rd(4'(15 - id)));
      end
   endtask

   task automatic apply(input string tag, input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input logic c, input logic [63:0] ve,
                        input logic [63:0] vm, input logic [3:0] sa, input logic [3:0] sb);
      icode = ic; rA = ra; rB = rb; Cnd = c; valE = ve; valM = vm; srcA = sa; srcB = sb;
      cur_de = exp_de(ic, rb, c);
      cur_dm = exp_dm(ic, ra);
      cur_ve = ve;
      cur_vm = vm;
      #1;
      chk({tag, " destE"}, 64'(destE), 64'(cur_de));
      chk({tag, " destM"}, 64'(destM), 64'(cur_dm));
      chk({tag, " pre valA"}, valA, exp_rd(sa));
      chk({tag, " pre valB"}, valB, exp_rd(sb));
      @(posedge CLK);
      if (!RST) begin
         if (cur_de != 4'hF) model[cur_de] = ve;
         if (cur_dm != 4'hF) model[cur_dm] = vm;
      end
      #1;
      $display("%s: icode=%h rA=%h rB=%h Cnd=%b valE=%h valM=%h destE=%h destM=%h",
               tag, ic, ra, rb, c, ve, vm, destE, destM);
   endtask

   task automatic read_one(input string tag, input logic [3:0] id, input logic [63:0] exp);
      srcA = id;
      #1;
      chk(tag, valA, exp);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) model[i] = '0;

      // Reset state: everything reads zero
      #10;
      sweep("reset");
      @(negedge CLK);
      RST = 1'b0;

      // IRMOV: rax <- 3, destM none
      apply("irmov", 4'h3, 4'h2, 4'h0, 1'b0, 64'd3, 64'd4, 4'h0, 4'h2);
      read_one("irmov rax", 4'h0, 64'd3);
      read_one("irmov rdx", 4'h2, 64'd0);
      sweep("irmov");

      // CMOV taken: rcx <- 7, valA reads old rax before edge
      apply("cmov1", 4'h2, 4'h0, 4'h1, 1'b1, 64'd7, 64'd0, 4'h0, 4'h1);
      read_one("cmov1 rcx", 4'h1, 64'd7);

      // CMOV not taken: rcx keeps 7
      apply("cmov0", 4'h2, 4'h0, 4'h1, 1'b0, 64'd9, 64'd0, 4'h0, 4'h1);
      read_one("cmov0 rcx", 4'h1, 64'd7);

      // POP %rsi then POP %rsp (M wins)
      apply("pop rsi", 4'hB, 4'h6, 4'hF, 1'b0, 64'd56, 64'd21, 4'h4, 4'h6);
      read_one("pop rsp", 4'h4, 64'd56);
      read_one("pop rsi", 4'h6, 64'd21);
      apply("pop rsp", 4'hB, 4'h4, 4'hF, 1'b0, 64'd64, 64'd99, 4'h4, 4'h4);
      read_one("popq rsp", 4'h4, 64'd99);

      // No-register read and HALT leave state untouched
      read_one("none read", 4'hF, 64'd0);
      apply("halt", 4'h0, 4'h3, 4'h5, 1'b1, 64'hDEAD, 64'hBEEF, 4'h3, 4'h5);
      sweep("halt");

      // Random instructions
      for (int n = 0; n < 150; n++) begin
         apply($sformatf("rnd%0d", n), 4'($urandom_range(0, 15)), 4'($urandom),
               4'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
               4'($urandom), 4'($urandom));
         if (n % 10 == 9) sweep($sformatf("rnd%0d", n));
      end

      // Make sure state is nonzero, then assert reset between edges
      apply("preload", 4'h3, 4'h0, 4'h7, 1'b0, 64'h1234, 64'd0, 4'h7, 4'h7);
      read_one("preload rdi", 4'h7, 64'h1234);
      RST = 1'b1;
      for (int i = 0; i < 16; i++) model[i] = '0;
      sweep("async rst");
      apply("rst write", 4'h3, 4'h0, 4'h5, 1'b0, 64'h55, 64'h66, 4'h5, 4'h4);
      read_one("rst rbp", 4'h5, 64'd0);
      sweep("rst hold");
      RST = 1'b0;
      apply("post rst", 4'h6, 4'h0, 4'h5, 1'b0, 64'h77, 64'h0, 4'h5, 4'h7);
      read_one("post rst rbp", 4'h5, 64'h77);
      sweep("post rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/y86_regfile.md
# y86_regfile

Y86-64 architectural register file for the decode/write-back stages of the CPU datapath, with the write-destination selection logic built in. Two combinational read ports are addressed by externally computed source IDs. Two write ports, E and M, are committed on the clock edge. The write destinations are derived internally from the instruction code, rA, rB and the condition flag Cnd.

## Interface
Parameters:
- DATA_WID, default 64: register and data width.
- ADDR_WID, default 4: register ID width.

Ports:
- CLK, input, 1: single clock; all writes occur on its rising edge.
- RST, input, 1: reset, asynchronous, active-high.
- icode, input, 4: instruction code.
- rA, input, ADDR_WID: register specifier A.
- rB, input, ADDR_WID: register specifier B.
- Cnd, input, 1: condition result, used by conditional moves.
- srcA, input, ADDR_WID: read port A register ID.
- srcB, input, ADDR_WID: read port B register ID.
- valE, input, DATA_WID: write data for port E.
- valM, input, DATA_WID: write data for port M.
- valA, output, DATA_WID: read data for port A.
- valB, output, DATA_WID: read data for port B.
- destE, output, ADDR_WID: computed E destination ID, exported for observation.
- destM, output, ADDR_WID: computed M destination ID, exported for observation.

## Operation
- Register IDs: 0 rax, 1 rcx, 2 rdx, 3 rbx, 4 rsp, 5 rbp, 6 rsi, 7 rdi, 8–14 r8–r14.
- ID 0xF means no register. Storage is 15 registers of DATA_WID bits.
- icode encoding: 0 HALT, 1 NOP, 2 RRMOV/CMOV, 3 IRMOV, 4 RMMOV, 5 MRMOV, 6 OP, 7 JXX, 8 CALL, 9 RET, A PUSH, B POP.
- destE, combinational:
  - RRMOV: rB if Cnd=1, else 0xF.
  - IRMOV, OP: rB.
  - PUSH, POP, CALL, RET: 4 (rsp).
  - All other icodes: 0xF.
- destM, combinational:
  - MRMOV, POP: rA.
  - All other icodes: 0xF.
- Reads are purely combinational: valA = reg[srcA], valB = reg[srcB].
  - srcA or srcB = 0xF reads as 0.
  - Both ports may address the same register.
- Writes, at each rising CLK edge with RST low:
  - If destE ≠ 0xF, reg[destE] ← valE.
  - If destM ≠ 0xF, reg[destM] ← valM.
  - If destE = destM ≠ 0xF, valM wins (this is the popq %rsp semantics).
- Writes to ID 0xF are discarded; no storage is modified.

## Timing
- Read latency is zero (combinational from srcA/srcB and register state).
- Write latency is one edge. Values written at edge N are visible on valA/valB immediately after edge N.
- Read-during-write to the same register in the same cycle returns the old value unless bypass is enabled (see Configuration).
- Reset behaviour:
  - RST high asynchronously clears all 15 registers to 0, so valA/valB read 0 for every ID.
  - While RST is high, no write takes effect.
  - If RST asserts mid-cycle, state is cleared immediately.
- Reset does not affect destE/destM; they stay purely combinational from their inputs.

## Configuration
- Macro REGFILE_WRITE_BYPASS_EN.
- Defined:
  - valA/valB forward the pending write data when the read ID equals a non-0xF destE or destM in the same cycle.
  - M has priority over E when both match.
- Undefined: no forwarding; reads return stored state only.

## Test plan
- Reset, then icode=3 (IRMOV), rA=2, rB=0, valE=3, valM=4, one edge:
  - rax=3, rdx=0 (destM=0xF).
  - destE=0, destM=0xF.
- Then icode=2, Cnd=1, rA=0, rB=1, valE=7, srcA=0, one edge:
  - valA=3 before the edge.
  - rcx=7 after the edge.
- Same as above but Cnd=0, valE=9:
  - destE=0xF, rcx unchanged.
- icode=B (POP), rA=6, valE=56, valM=21:
  - rsp=56, rsi=21.
  - Then rA=4, valE=64, valM=99: rsp=99 (M priority).
- srcA=0xF after arbitrary writes: valA=0. icode=0 (HALT): no register changes.
- Assert RST asynchronously between edges with nonzero state: all reads 0 immediately, and the next edge with RST still high performs no write.
